// File: rtl/stack_pkg.sv
// stack_pkg: op codes, FSM state type and default widths shared between the
// stack memory controller and the stack-processor datapath.
package stack_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/stack_ptr_ctr.sv
// stack_ptr_ctr: saturating up/down entry counter for the data stack.
// Produces the entry count and the full/empty flags derived from it.
module stack_ptr_ctr
  import stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            clka,
  input  logic            rst_n,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [ADDR_W:0] o_sp,
  output logic            o_full,
  output logic            o_empty
);

  localparam logic [ADDR_W:0] SP_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] SP_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] r_sp;

  // count moves one step per request and sticks at either end instead of wrapping
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (i_inc && !i_dec && (r_sp != SP_MAX)) begin
      r_sp <= r_sp + SP_ONE;
    end else if (i_dec && !i_inc && (r_sp != '0)) begin
      r_sp <= r_sp - SP_ONE;
    end
  end

  assign o_sp    = r_sp;
  assign o_full  = (r_sp == SP_MAX);
  assign o_empty = (r_sp == '0);

endmodule

// File: rtl/stack_mem_ctrl.sv
// stack_mem_ctrl: owns the single-port data-stack RAM and turns push/pop/peek
// commands into registered memory cycles. Keeps sp, full/empty and sticky
// error flags.
// Optional build macro STACK_MEM_CLEAR_EN: zero-fill the whole RAM after reset
// before accepting the first command.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a command; errored commands are absorbed here
// ST_ISSUE | memory cycle on the port (write for push, address for read)
// ST_WAIT  | extra read-latency cycles, address held
// ST_RESP  | rsp_valid pulse with mem_douta; pop decrements sp
// ST_CLEAR | post-reset zero-fill sweep (STACK_MEM_CLEAR_EN only)
module stack_mem_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W:0]   sp,
  output logic              empty,
  output logic              full,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_op,
  input  logic              err_clr,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta
);

  localparam logic [1:0]        WAIT_LOAD = 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_op;
  logic [1:0]        r_wait_cnt;
  logic              r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina;
  logic [DATA_W-1:0] r_rsp_hold;
  logic              r_err_ovf;
  logic              r_err_unf;
  logic              r_err_op;

  logic              w_accept;
  logic              w_is_rd;
  logic              w_push_ok;
  logic              w_rd_ok;
  logic              w_ovf;
  logic              w_unf;
  logic              w_rsvd;
  logic              w_inc;
  logic              w_dec;
  logic [ADDR_W-1:0] w_sp_lo;

`ifdef STACK_MEM_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_cnt;
`endif

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_is_rd   = (cmd_op == OP_POP) || (cmd_op == OP_PEEK);
  assign w_push_ok = w_accept && (cmd_op == OP_PUSH) && !full;
  assign w_rd_ok   = w_accept && w_is_rd && !empty;
  assign w_ovf     = w_accept && (cmd_op == OP_PUSH) && full;
  assign w_unf     = w_accept && w_is_rd && empty;
  assign w_rsvd    = w_accept && (cmd_op == OP_RSVD);
  assign w_sp_lo   = sp[ADDR_W-1:0];

  // sp moves only when the memory side of the command actually happens
  assign w_inc = (r_state == ST_ISSUE) && (r_op == OP_PUSH);
  assign w_dec = (r_state == ST_RESP) && (r_op == OP_POP);

  stack_ptr_ctr #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clka    (clka),
    .rst_n   (rst_n),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_sp    (sp),
    .o_full  (full),
    .o_empty (empty)
  );

  // next-state decode and the response strobe
  always_comb begin
    w_next    = r_state;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_push_ok || w_rd_ok) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (r_op == OP_PUSH)       w_next = ST_IDLE;
        else if (READ_LATENCY > 1) w_next = ST_WAIT;
        else                       w_next = ST_RESP;
      end
      ST_WAIT: begin
        if (r_wait_cnt == 2'd0) w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        w_next    = ST_IDLE;
      end
`ifdef STACK_MEM_CLEAR_EN
      ST_CLEAR: begin
        if (r_clr_cnt == {ADDR_W{1'b1}}) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // state register, latched op and read-latency down-counter
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
`ifdef STACK_MEM_CLEAR_EN
      r_state <= ST_CLEAR;
`else
      r_state <= ST_IDLE;
`endif
      r_op       <= OP_PUSH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_op <= cmd_op;
      if (r_state == ST_ISSUE) begin
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != 2'd0)) begin
        r_wait_cnt <= r_wait_cnt - 2'd1;
      end
    end
  end

`ifdef STACK_MEM_CLEAR_EN
  // sweep address for the post-reset zero fill
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + ADDR_ONE;
    end
  end
`endif

  // memory port registers: loaded on accept so they are live during ISSUE;
  // a read address stays put until the next accepted command
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
    end else begin
      r_wea <= 1'b0;
      if (w_push_ok) begin
        r_wea   <= 1'b1;
        r_addra <= w_sp_lo;
        r_dina  <= cmd_data;
      end else if (w_rd_ok) begin
        r_addra <= w_sp_lo - ADDR_ONE;
      end
`ifdef STACK_MEM_CLEAR_EN
      else if (r_state == ST_CLEAR) begin
        r_wea   <= 1'b1;
        r_addra <= r_clr_cnt;
        r_dina  <= '0;
      end
`endif
    end
  end

  // sticky error flags; a new error in the same cycle as err_clr wins
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
      r_err_op  <= 1'b0;
    end else begin
      r_err_ovf <= w_ovf  || (r_err_ovf && !err_clr);
      r_err_unf <= w_unf  || (r_err_unf && !err_clr);
      r_err_op  <= w_rsvd || (r_err_op  && !err_clr);
    end
  end

  // remember the last response word so rsp_data holds between pulses
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_hold <= '0;
    end else if (r_state == ST_RESP) begin
      r_rsp_hold <= mem_douta;
    end
  end

  assign rsp_data  = rsp_valid ? mem_douta : r_rsp_hold;
  assign mem_wea   = r_wea;
  assign mem_addra = r_addra;
  assign mem_dina  = r_dina;
  assign err_ovf   = r_err_ovf;
  assign err_unf   = r_err_unf;
  assign err_op    = r_err_op;

endmodule
